// File: rtl/bcode_time_pkg.sv
// Shared constants, state encodings and BCD helper for the B-code time frame receiver.
package bcode_time_pkg;

  localparam logic [7:0] HDR0      = 8'hAA;
  localparam logic [7:0] HDR1      = 8'h55;
  localparam int         FRAME_LEN = 9;
  localparam int         PAY_LEN   = FRAME_LEN - 3;

  localparam logic [7:0]  SEC_MAX  = 8'h59;
  localparam logic [7:0]  MIN_MAX  = 8'h59;
  localparam logic [7:0]  HOUR_MAX = 8'h23;
  localparam logic [11:0] DAY_MIN  = 12'h001;
  localparam logic [11:0] DAY_MAX  = 12'h366;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {P_H0, P_H1, P_PAY, P_CHK} parse_state_t;

  function automatic logic bcd_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, mid-bit sampling, one-cycle byte_vld / byte_err.
module uart_rx_byte
  import bcode_time_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_vld,
  output logic       byte_err,
  output logic [7:0] data
);

  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CW      = $clog2(BIT_CNT + 1);

  logic          rx_meta, rx_s, rx_q;
  rx_state_t     state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic          half_done, bit_done, fall;

  assign half_done = (cnt == CW'(HALF - 1));
  assign bit_done  = (cnt == CW'(BIT_CNT - 1));
  // rx_q is a delayed copy of the synchronised line, used only for edge detection.
  assign fall      = rx_q & ~rx_s;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbour.
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= R_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      R_IDLE:  if (fall) state_nxt = R_START;
      R_START: if (half_done) state_nxt = rx_s ? R_IDLE : R_DATA;
      R_DATA:  if (bit_done && bit_idx == 3'd7) state_nxt = R_STOP;
      R_STOP:  if (bit_done) state_nxt = R_IDLE;
      default: state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      data    <= '0;
    end else begin
      unique case (state)
        R_START: begin
          cnt     <= half_done ? '0 : cnt + 1'b1;
          bit_idx <= '0;
        end
        R_DATA: begin
          if (bit_done) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 1'b1;
            data    <= {rx_s, data[7:1]};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        R_STOP:  cnt <= bit_done ? '0 : cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    byte_vld = (state == R_STOP) && bit_done &&  rx_s;
    byte_err = (state == R_STOP) && bit_done && !rx_s;
  end

endmodule

// File: rtl/uart_recv_bcode_time.sv
// B-code time frame receiver: parses AA 55 + 6 BCD payload bytes + checksum, latches validated time.
module uart_recv_bcode_time
  import bcode_time_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        time_valid,
  output logic        frame_err,
  output logic [7:0]  sec,
  output logic [7:0]  min,
  output logic [7:0]  hour,
  output logic [11:0] day,
  output logic [7:0]  year
);

  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int TO_CYC  = TIMEOUT_BITS * BIT_CNT;
  localparam int TW      = $clog2(TO_CYC + 1);

  logic         byte_vld, byte_err;
  logic [7:0]   rx_data;
  parse_state_t pstate, pstate_nxt;
  logic [2:0]   idx;
  logic [7:0]   sum;
  logic [7:0]   shadow [PAY_LEN];
  logic [TW-1:0] to_cnt;
  logic         timeout, abort, chk_vld, frame_good, all_bcd;
  logic [11:0]  day_v;

  uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .byte_vld (byte_vld),
    .byte_err (byte_err),
    .data     (rx_data)
  );

  always_ff @(posedge clk) begin
    if (rst) pstate <= P_H0;
    else     pstate <= pstate_nxt;
  end

  always_comb begin
    pstate_nxt = pstate;
    if (abort) begin
      pstate_nxt = P_H0;
    end else if (byte_vld) begin
      unique case (pstate)
        P_H0:  if (rx_data == HDR0) pstate_nxt = P_H1;
        P_H1:  pstate_nxt = (rx_data == HDR1) ? P_PAY : (rx_data == HDR0) ? P_H1 : P_H0;
        P_PAY: if (idx == 3'(PAY_LEN - 1)) pstate_nxt = P_CHK;
        P_CHK: pstate_nxt = P_H0;
        default: pstate_nxt = P_H0;
      endcase
    end
  end

  // A byte arriving in the expiry cycle beats the timeout.
  always_comb begin
    timeout = (pstate != P_H0) && !byte_vld && (to_cnt == TW'(TO_CYC - 1));
    abort   = timeout || (byte_err && pstate != P_H0);
    chk_vld = (pstate == P_CHK) && byte_vld;
    day_v   = {shadow[4][3:0], shadow[3]};
    all_bcd = 1'b1;
    for (int i = 0; i < PAY_LEN; i++) all_bcd &= bcd_ok(shadow[i]);
    frame_good = (sum == rx_data) && all_bcd && (shadow[4][7:4] == 4'd0) &&
                 (shadow[0] <= SEC_MAX) && (shadow[1] <= MIN_MAX) &&
                 (shadow[2] <= HOUR_MAX) && (day_v >= DAY_MIN) && (day_v <= DAY_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst || pstate == P_H0 || byte_vld) to_cnt <= '0;
    else                                   to_cnt <= to_cnt + 1'b1;
  end

  // Sum and index restart whenever the parser is hunting for a header.
  always_ff @(posedge clk) begin
    if (rst || pstate == P_H0 || pstate == P_H1) begin
      idx <= '0;
      sum <= '0;
    end else if (pstate == P_PAY && byte_vld) begin
      idx <= idx + 1'b1;
      sum <= sum + rx_data;
    end
  end

  // NOTE: shadow bytes carry no reset; they are only read after a complete frame has rewritten all six.
  always_ff @(posedge clk) begin
    if (pstate == P_PAY && byte_vld) shadow[idx] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      time_valid <= 1'b0;
      frame_err  <= 1'b0;
      sec        <= '0;
      min        <= '0;
      hour       <= '0;
      day        <= '0;
      year       <= '0;
    end else begin
      time_valid <= chk_vld && frame_good;
      frame_err  <= abort || (chk_vld && !frame_good);
      if (chk_vld && frame_good) begin
        sec  <= shadow[0];
        min  <= shadow[1];
        hour <= shadow[2];
        day  <= day_v;
        year <= shadow[5];
      end
    end
  end

endmodule
